// File: rtl/wb_commit_unit.sv
// wb_commit_unit: registered write-back / commit stage between the memory
// stage and the register file. Accepts one instruction per cycle, waits for
// late load data when needed, aligns/extends it and writes the register file
// one cycle later. Single retirement point of the pipeline.
// Optional feature: define WB_RETIRE_CNT_EN to build the 64-bit retire counter;
// otherwise retire_cnt is tied to 0.
//
// state     | meaning
// IDLE      | ready to accept; non-load accepts commit on the next edge
// WAIT_LOAD | load accepted, waiting for ld_valid; commits on the next edge
module wb_commit_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int OFF_W   = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         wb_sel,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [XLEN-1:0]    pc_plus4,
  input  logic [XLEN-1:0]    imm_u,
  input  logic [2:0]         funct3,
  input  logic [OFF_W-1:0]   addr_lo,
  input  logic [RADDR_W-1:0] rd,
  input  logic               reg_write,
  input  logic               ld_valid,
  input  logic [XLEN-1:0]    ld_data,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               retire,
  output logic [63:0]        retire_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  state_t             state;
  logic [RADDR_W-1:0] rd_q;
  logic               reg_write_q;
  logic [2:0]         funct3_q;
  logic [OFF_W-1:0]   addr_lo_q;

  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    ld_aligned;
  logic [XLEN-1:0]    nonload_val;
  logic               accept;

  // Reset wins over any handshake in the same cycle.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Non-load result select at accept time.
  always_comb begin
    nonload_val = alu_result;
    case (wb_sel)
      2'b10:   nonload_val = pc_plus4;
      2'b11:   nonload_val = imm_u;
      default: nonload_val = alu_result;
    endcase
  end

  // Load alignment and sign/zero extension using the latched size and offset.
  // Misaligned offsets are not trapped; whatever shifts down is used.
  always_comb begin
    shifted    = ld_data >> {addr_lo_q, 3'b000};
    ld_aligned = XLEN'($signed(shifted[31:0]));
    case (funct3_q)
      3'b000: ld_aligned = XLEN'($signed(shifted[7:0]));
      3'b001: ld_aligned = XLEN'($signed(shifted[15:0]));
      3'b100: ld_aligned = XLEN'(shifted[7:0]);
      3'b101: ld_aligned = XLEN'(shifted[15:0]);
      3'b010: ld_aligned = XLEN'($signed(shifted[31:0]));
      3'b110: ld_aligned = (XLEN == 64) ? XLEN'(shifted[31:0])
                                        : XLEN'($signed(shifted[31:0]));
      default: ld_aligned = (XLEN == 64) ? shifted
                                         : XLEN'($signed(shifted[31:0]));
    endcase
  end

  // Commit FSM with registered register-file port and retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      retire      <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q        <= rd;
            reg_write_q <= reg_write;
            funct3_q    <= funct3;
            addr_lo_q   <= addr_lo;
            if (wb_sel == 2'b01) begin
              state <= WAIT_LOAD;
            end else begin
              retire <= 1'b1;
              if (reg_write && (rd != '0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= rd;
                rf_wdata <= nonload_val;
              end
            end
          end
        end
        WAIT_LOAD: begin
          if (ld_valid) begin
            state  <= IDLE;
            retire <= 1'b1;
            if (reg_write_q && (rd_q != '0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd_q;
              rf_wdata <= ld_aligned;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q;

  // Count every retirement, including discarded x0 / no-write commits.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 64'd1;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: XLEN=32 instance for most checks plus an
// XLEN=64 instance for the 64-bit-only load codes.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        in_valid, in_ready, reg_write, ld_valid;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, pc_plus4, imm_u, ld_data;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [4:0]  rd;
  logic        rf_we, retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] retire_cnt;

  wb_commit_unit #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .alu_result(alu_result), .pc_plus4(pc_plus4),
    .imm_u(imm_u), .funct3(funct3), .addr_lo(addr_lo), .rd(rd),
    .reg_write(reg_write), .ld_valid(ld_valid), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .retire_cnt(retire_cnt)
  );

  // XLEN=64 instance
  logic        in_valid64, in_ready64, ld_valid64;
  logic [2:0]  funct3_64;
  logic [2:0]  addr_lo64;
  logic [63:0] ld_data64;
  logic        rf_we64, retire64;
  logic [4:0]  rf_waddr64;
  logic [63:0] rf_wdata64;
  logic [63:0] retire_cnt64;

  wb_commit_unit #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .wb_sel(2'b01), .alu_result(64'h0), .pc_plus4(64'h0),
    .imm_u(64'h0), .funct3(funct3_64), .addr_lo(addr_lo64), .rd(5'd4),
    .reg_write(1'b1), .ld_valid(ld_valid64), .ld_data(ld_data64),
    .rf_we(rf_we64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64),
    .retire(retire64), .retire_cnt(retire_cnt64)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_cnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_retire();
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = exp_cnt + 64'd1;
`endif
  endtask

  // Multi-cycle load: accept (with a same-cycle ld_valid that must be ignored),
  // lat stall cycles, then commit.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] r, input logic [31:0] data, input int lat,
                         input logic [31:0] exp_data);
    in_valid = 1'b1; wb_sel = 2'b01; funct3 = f3; addr_lo = off; rd = r; reg_write = 1'b1;
    ld_valid = 1'b1; ld_data = 32'h5A5A_5A5A;
    step();
    in_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk({name, "_stall_ready"}, {63'b0, in_ready}, 64'd0);
      chk({name, "_stall_retire"}, {63'b0, retire}, 64'd0);
      if (i == lat) begin
        ld_valid = 1'b1; ld_data = data;
      end
      step();
    end
    ld_valid = 1'b0;
    count_retire();
    chk({name, "_retire"}, {63'b0, retire}, 64'd1);
    chk({name, "_we"}, {63'b0, rf_we}, 64'd1);
    chk({name, "_waddr"}, {59'b0, rf_waddr}, {59'b0, r});
    chk({name, "_wdata"}, {32'b0, rf_wdata}, {32'b0, exp_data});
    chk({name, "_ready_back"}, {63'b0, in_ready}, 64'd1);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  r;
    logic        rw;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[6];

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] data;
    logic [63:0] exp;
  } v64_t;

  v64_t v64[4];

  initial begin
    vecs[0] = '{2'b00, 32'h0000_1234, 32'h2222_2222, 32'h3333_3333, 5'd5,  1'b1, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{2'b10, 32'h1111_1111, 32'h0000_0104, 32'h3333_3333, 5'd0,  1'b1, 1'b0, 5'd5,  32'h0000_1234};
    vecs[2] = '{2'b10, 32'h1111_1111, 32'h0000_0104, 32'h3333_3333, 5'd1,  1'b1, 1'b1, 5'd1,  32'h0000_0104};
    vecs[3] = '{2'b11, 32'h1111_1111, 32'h2222_2222, 32'hABCD_E000, 5'd31, 1'b1, 1'b1, 5'd31, 32'hABCD_E000};
    vecs[4] = '{2'b00, 32'h0000_DEAD, 32'h2222_2222, 32'h3333_3333, 5'd9,  1'b0, 1'b0, 5'd31, 32'hABCD_E000};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'h2222_2222, 32'h3333_3333, 5'd2,  1'b1, 1'b1, 5'd2,  32'hFFFF_FFFF};

    v64[0] = '{3'b110, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF};
    v64[1] = '{3'b011, 3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    v64[2] = '{3'b111, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    v64[3] = '{3'b010, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};

    rst = 1'b1;
    in_valid = 1'b1; wb_sel = 2'b00; alu_result = 32'h1; pc_plus4 = 32'h0; imm_u = 32'h0;
    funct3 = 3'b000; addr_lo = 2'd0; rd = 5'd3; reg_write = 1'b1; ld_valid = 1'b0; ld_data = 32'h0;
    in_valid64 = 1'b0; ld_valid64 = 1'b0; funct3_64 = 3'b000; addr_lo64 = 3'd0; ld_data64 = 64'h0;
    step(); step();
    // accept attempted during reset must be overridden
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_rf_we", {63'b0, rf_we}, 64'd0);
    chk("rst_waddr", {59'b0, rf_waddr}, 64'd0);
    chk("rst_wdata", {32'b0, rf_wdata}, 64'd0);
    chk("rst_retire", {63'b0, retire}, 64'd0);
    chk("rst_cnt", retire_cnt, 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'b0, in_ready}, 64'd1);

    // back-to-back non-load table
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; wb_sel = vecs[i].sel; alu_result = vecs[i].alu;
      pc_plus4 = vecs[i].pc4; imm_u = vecs[i].imm; rd = vecs[i].r; reg_write = vecs[i].rw;
      step();
      count_retire();
      chk($sformatf("vec%0d_retire", i), {63'b0, retire}, 64'd1);
      chk($sformatf("vec%0d_we", i), {63'b0, rf_we}, {63'b0, vecs[i].we});
      chk($sformatf("vec%0d_waddr", i), {59'b0, rf_waddr}, {59'b0, vecs[i].waddr});
      chk($sformatf("vec%0d_wdata", i), {32'b0, rf_wdata}, {32'b0, vecs[i].wdata});
    end
    in_valid = 1'b0;
    step();
    chk("idle_retire", {63'b0, retire}, 64'd0);
    chk("cnt_after_vecs", retire_cnt, exp_cnt);

    // loads with various latencies
    do_load("lb",  3'b000, 2'd3, 5'd7,  32'h80FF_7F01, 3, 32'hFFFF_FF80);
    do_load("lhu", 3'b101, 2'd2, 5'd7,  32'h80FF_7F01, 3, 32'h0000_80FF);
    do_load("lh",  3'b001, 2'd0, 5'd8,  32'h80FF_7F01, 1, 32'h0000_7F01);
    do_load("lbu", 3'b100, 2'd3, 5'd9,  32'h80FF_7F01, 2, 32'h0000_0080);
    do_load("lb1", 3'b000, 2'd1, 5'd10, 32'h80FF_7F01, 1, 32'h0000_007F);
    do_load("ld32", 3'b111, 2'd0, 5'd11, 32'h80FF_7F01, 2, 32'h80FF_7F01);
    step();
    chk("cnt_after_loads", retire_cnt, exp_cnt);

    // reset in WAIT_LOAD abandons the load; late response ignored
    in_valid = 1'b1; wb_sel = 2'b01; funct3 = 3'b010; addr_lo = 2'd0; rd = 5'd3; reg_write = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_ready", {63'b0, in_ready}, 64'd0);
    rst = 1'b0;
    exp_cnt = 64'd0;
    ld_valid = 1'b1; ld_data = 32'hCAFE_F00D;
    step();
    ld_valid = 1'b0;
    chk("midrst_we", {63'b0, rf_we}, 64'd0);
    chk("midrst_retire", {63'b0, retire}, 64'd0);
    chk("midrst_ready_back", {63'b0, in_ready}, 64'd1);
    chk("midrst_wdata", {32'b0, rf_wdata}, 64'd0);
    step();
    chk("midrst_cnt", retire_cnt, 64'd0);

    // stray ld_valid in IDLE
    ld_valid = 1'b1; ld_data = 32'h1234_5678;
    step();
    ld_valid = 1'b0;
    chk("stray_we", {63'b0, rf_we}, 64'd0);
    chk("stray_retire", {63'b0, retire}, 64'd0);

    // 10 back-to-back non-loads
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; wb_sel = 2'b00; alu_result = 32'(i); rd = 5'd12; reg_write = 1'b1;
      step();
      count_retire();
      chk($sformatf("b2b%0d_we", i), {63'b0, rf_we}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_wdata", {32'b0, rf_wdata}, 64'd9);
    chk("b2b_cnt", retire_cnt, exp_cnt);

`ifdef WB_RETIRE_CNT_EN
    chk("cnt_ten", retire_cnt, 64'd10);
    @(negedge clk);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    chk("cnt_forced", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b1; wb_sel = 2'b10; pc_plus4 = 32'h104; rd = 5'd0; reg_write = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("cnt_wrap", retire_cnt, 64'd0);
`endif

    // XLEN=64 load codes
    for (int i = 0; i < 4; i++) begin
      in_valid64 = 1'b1; funct3_64 = v64[i].f3; addr_lo64 = v64[i].off;
      step();
      in_valid64 = 1'b0;
      ld_valid64 = 1'b1; ld_data64 = v64[i].data;
      step();
      ld_valid64 = 1'b0;
      chk($sformatf("x64_%0d_we", i), {63'b0, rf_we64}, 64'd1);
      chk($sformatf("x64_%0d_wdata", i), rf_wdata64, v64[i].exp);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Parametrised, registered write-back/commit stage that replaces the purely combinational write-back select. It accepts one instruction per cycle from the memory stage over a valid/ready handshake. It selects the result source, aligns and sign/zero-extends load data that may return several cycles late, and drives the register-file write port one cycle later. It sits between the memory stage and the register file, and it is the single point where instructions retire.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- RADDR_W, 5: register address width.
- OFF_W, $clog2(XLEN/8): byte-offset width, derived; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  unit can accept; high only in IDLE and when rst=0.
- wb_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM_U.
- alu_result  in  XLEN  ALU result.
- pc_plus4  in  XLEN  link value for JAL/JALR.
- imm_u  in  XLEN  LUI immediate, already shifted.
- funct3  in  3  load size/sign code.
- addr_lo  in  OFF_W  load byte offset within the XLEN-wide data word.
- rd  in  RADDR_W  destination register.
- reg_write  in  1  instruction writes rd.
- ld_valid  in  1  load response strobe.
- ld_data  in  XLEN  naturally aligned memory word.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  RADDR_W  write address, registered.
- rf_wdata  out  XLEN  write data, registered.
- retire  out  1  registered one-cycle pulse per committed instruction.
- retire_cnt  out  64  retired-instruction count.

## Operation
- Accept: in_valid && in_ready. On accept, latch rd, reg_write, wb_sel, funct3 and addr_lo.
- FSM states:
  - IDLE. A non-load accept keeps the state at IDLE. An accept with wb_sel=01 moves to WAIT_LOAD.
  - WAIT_LOAD. On ld_valid, move to IDLE.
- ld_valid is ignored in IDLE. It is never counted and never written.
- Commit happens on the edge after a non-load accept, or on the edge after ld_valid in WAIT_LOAD.
  - retire=1 for that one cycle.
  - rf_we = reg_write && (rd != 0).
  - rf_waddr = rd.
  - rf_wdata = selected value.
- When rf_we=0, rf_waddr and rf_wdata hold their previous values.
- Load alignment: shift ld_data right by 8*addr_lo, then extend:
  - 000 LB: sign-extend bits [7:0].
  - 001 LH: sign-extend bits [15:0].
  - 100 LBU: zero-extend bits [7:0].
  - 101 LHU: zero-extend bits [15:0].
  - 010 LW: sign-extend bits [31:0].
  - 110 LWU: zero-extend bits [31:0]; XLEN=64 only.
  - 011 LD: full word; XLEN=64 only.
- When XLEN=32, codes 011, 110 and 111 behave as LW. When XLEN=64, code 111 behaves as LD.
- Misaligned offsets are not checked; the shifted bits are used as-is.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, retire_cnt=0, state IDLE, in_ready=0 while rst=1.
- Non-load latency is 1 cycle, accept to rf_we. Back-to-back accepts give rf_we on consecutive cycles.
- Load latency is the ld_valid cycle + 1.
  - in_ready=0 from the cycle after the load accept through the ld_valid cycle.
  - in_ready returns to 1 in the commit cycle, so there is at least one accept-free cycle per load.
- ld_valid in the same cycle as a load accept is ignored. The earliest usable response is the next cycle.
- rst asserted in WAIT_LOAD abandons the pending load: no write, no retire, state goes to IDLE. A late ld_valid after reset is then ignored.
- rst overrides an accept or an ld_valid in the same cycle.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_cnt increments by 1 on every retire pulse, including rd=0 and reg_write=0 commits.
  - Width is 64 bits; it wraps from 2^64-1 to 0.
  - Reset clears it to 0.
- WB_RETIRE_CNT_EN undefined: the counter is not built, retire_cnt is constant 0, and the port remains.

## Test plan
- ALU op: accept wb_sel=00, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234, retire=1.
- LB with 3-cycle latency (XLEN=32): ld_data=0x80FF_7F01, addr_lo=3, funct3=000, rd=7; ld_valid arrives 3 cycles after accept.
  - in_ready=0 for 3 cycles.
  - Commit the cycle after ld_valid with rf_wdata=0xFFFF_FF80.
  - Repeat with LHU, addr_lo=2 -> 0x0000_80FF.
- x0 and JAL:
  - wb_sel=10, pc_plus4=0x104, rd=0 -> rf_we=0, retire=1, retire_cnt +1.
  - rd=1 -> rf_wdata=0x104.
- Reset mid-load: accept LW, assert rst for 1 cycle, then pulse ld_valid -> no rf_we, no retire, in_ready=1 after reset.
- Stray ld_valid in IDLE with no accept -> no rf_we, no retire.
  - XLEN=64 LWU of 0xFFFF_FFFF_8000_0000 at addr_lo=4 -> 0x0000_0000_FFFF_FFFF.
- Counter (WB_RETIRE_CNT_EN defined): 10 back-to-back non-loads -> retire_cnt=10. Force the count to 2^64-1, then one retire -> 0.
